// File: rtl/cdb_arbiter.sv
// Common Data Bus transmit side: per-source writeback FIFOs drained round-robin onto CDB_PORTS lanes.
// Optional build macro CDB_PERF_CNT_EN adds per-source saturating stall counters (stall_cnt_o).
package uarch_pkg;
  localparam int TAG_WIDTH = 5;
  localparam int XLEN      = 32;

  typedef struct packed {
    logic [TAG_WIDTH-1:0] dest_tag;
    logic [XLEN-1:0]      result;
    logic                 is_valid;
    logic                 is_exception;
  } writeback_packet_t;
endpackage

module cdb_arbiter
  import uarch_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int CDB_PORTS = 2,
  parameter int QDEPTH    = 2,
  localparam int SRC_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  writeback_packet_t [NUM_SRC-1:0]      fu_wb_i,
  output logic [NUM_SRC-1:0]                   fu_ready_o,
  output writeback_packet_t [CDB_PORTS-1:0]    cdb_o,
  output logic [CDB_PORTS-1:0][SRC_W-1:0]      cdb_src_o
`ifdef CDB_PERF_CNT_EN
  ,
  output logic [NUM_SRC-1:0][31:0]             stall_cnt_o
`endif
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QDEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [SRC_W:0]   NSRC_C  = (SRC_W + 1)'(NUM_SRC);

  writeback_packet_t mem [NUM_SRC][QDEPTH];
  logic [PTR_W-1:0]  rd_ptr [NUM_SRC];
  logic [PTR_W-1:0]  wr_ptr [NUM_SRC];
  logic [CNT_W-1:0]  count  [NUM_SRC];
  logic [SRC_W-1:0]  rr_ptr;
  logic [SRC_W-1:0]  rr_next;

  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] grant;
  logic [CDB_PORTS-1:0]            lane_vld;
  logic [CDB_PORTS-1:0][SRC_W-1:0] lane_src;

  logic [SRC_W:0]   cand;
  logic [SRC_W:0]   nxt;
  logic [SRC_W-1:0] idx;
  logic             found;

  // Handshake: a source transfers when fu_wb_i[i].is_valid && fu_ready_o[i] at the clock
  // edge. Ready depends only on FIFO occupancy, never on valid or on a same-cycle pop.
  always_comb begin
    empty = '0;
    full  = '0;
    push  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      empty[i] = (count[i] == '0);
      full[i]  = (count[i] == DEPTH_C);
      push[i]  = fu_wb_i[i].is_valid && !full[i] && !flush;
    end
  end

  assign fu_ready_o = ~full;

  // Each lane takes the next non-empty, not-yet-granted source scanning up from rr_ptr.
  always_comb begin
    grant    = '0;
    lane_vld = '0;
    lane_src = '0;
    rr_next  = rr_ptr;
    cand     = '0;
    nxt      = '0;
    idx      = '0;
    found    = 1'b0;
    for (int k = 0; k < CDB_PORTS; k++) begin
      found = 1'b0;
      for (int j = 0; j < NUM_SRC; j++) begin
        cand = {1'b0, rr_ptr} + (SRC_W + 1)'(j);
        if (cand >= NSRC_C) cand = cand - NSRC_C;
        idx = cand[SRC_W-1:0];
        if (!found && !flush && !empty[idx] && !grant[idx]) begin
          found       = 1'b1;
          grant[idx]  = 1'b1;
          lane_vld[k] = 1'b1;
          lane_src[k] = idx;
          nxt = {1'b0, idx} + (SRC_W + 1)'(1);
          if (nxt >= NSRC_C) nxt = '0;
          rr_next = nxt[SRC_W-1:0];
        end
      end
    end
  end

  always_comb begin
    cdb_o     = '0;
    cdb_src_o = '0;
    for (int k = 0; k < CDB_PORTS; k++) begin
      if (lane_vld[k]) begin
        cdb_o[k]     = mem[lane_src[k]][rd_ptr[lane_src[k]]];
        cdb_src_o[k] = lane_src[k];
      end
    end
  end

  // Payload storage carries no reset; occupancy is tracked solely by count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= fu_wb_i[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      if (|grant) rr_ptr <= rr_next;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i])  wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
        if (grant[i]) rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
        if (push[i] && !grant[i])      count[i] <= count[i] + CNT_ONE;
        else if (!push[i] && grant[i]) count[i] <= count[i] - CNT_ONE;
      end
    end
  end

`ifdef CDB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rst) stall_cnt_o[i] <= '0;
      else if (!empty[i] && !grant[i] && (stall_cnt_o[i] != '1))
        stall_cnt_o[i] <= stall_cnt_o[i] + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        assert (count[i] <= DEPTH_C);
        assert (!(push[i] && !fu_ready_o[i]));
      end
      for (int k = 0; k < CDB_PORTS; k++) begin
        for (int l = k + 1; l < CDB_PORTS; l++) begin
          assert (!(lane_vld[k] && lane_vld[l] && (lane_src[k] == lane_src[l])));
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, hand sequences, and randomized traffic
// checked against a queue-based model of the CDB arbitration rules.
module tb_cdb_arbiter;
  import uarch_pkg::*;

  localparam int NUM_SRC   = 4;
  localparam int CDB_PORTS = 2;
  localparam int QDEPTH    = 2;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  writeback_packet_t [NUM_SRC-1:0]   fu_wb;
  logic [NUM_SRC-1:0]                fu_ready;
  writeback_packet_t [CDB_PORTS-1:0] cdb;
  logic [CDB_PORTS-1:0][1:0]         cdb_src;
`ifdef CDB_PERF_CNT_EN
  logic [NUM_SRC-1:0][31:0]          stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cdb_arbiter #(.NUM_SRC(NUM_SRC), .CDB_PORTS(CDB_PORTS), .QDEPTH(QDEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .fu_wb_i    (fu_wb),
    .fu_ready_o (fu_ready),
    .cdb_o      (cdb),
    .cdb_src_o  (cdb_src)
`ifdef CDB_PERF_CNT_EN
    ,
    .stall_cnt_o(stall_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] res_of(input logic [4:0] t);
    return 32'hC0DE_0000 | {27'd0, t};
  endfunction

  function automatic writeback_packet_t pkt(input logic [4:0] t, input logic [31:0] r, input logic e);
    writeback_packet_t p;
    p.dest_tag     = t;
    p.result       = r;
    p.is_valid     = 1'b1;
    p.is_exception = e;
    return p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [38:0] mq [NUM_SRC][$];
  int          rr;
  int          m_stall [NUM_SRC];
  int          g_src [CDB_PORTS];
  int          g_n;
  logic [40:0] exp_q[$];

  function automatic void model_clear();
    for (int i = 0; i < NUM_SRC; i++) begin
      mq[i].delete();
      m_stall[i] = 0;
    end
    rr = 0;
    exp_q.delete();
  endfunction

  // Winners are the first CDB_PORTS non-empty queues visited going upward from rr.
  function automatic void model_predict(input logic fl);
    int s;
    g_n = 0;
    for (int j = 0; j < NUM_SRC; j++) begin
      s = (rr + j) % NUM_SRC;
      if (!fl && mq[s].size() > 0 && g_n < CDB_PORTS) begin
        g_src[g_n] = s;
        g_n++;
      end
    end
    for (int k = 0; k < CDB_PORTS; k++) begin
      if (k < g_n) exp_q.push_back({2'(g_src[k]), mq[g_src[k]][0]});
      else         exp_q.push_back('0);
    end
  endfunction

  function automatic void model_commit(input logic [NUM_SRC-1:0] vld,
                                       input writeback_packet_t [NUM_SRC-1:0] pk,
                                       input logic fl, input logic [NUM_SRC-1:0] rdy);
    bit granted;
    for (int i = 0; i < NUM_SRC; i++) begin
      granted = 1'b0;
      for (int k = 0; k < g_n; k++) if (g_src[k] == i) granted = 1'b1;
      if (mq[i].size() > 0 && !granted) m_stall[i]++;
    end
    if (fl) begin
      for (int i = 0; i < NUM_SRC; i++) mq[i].delete();
    end else begin
      for (int k = 0; k < g_n; k++) void'(mq[g_src[k]].pop_front());
      for (int i = 0; i < NUM_SRC; i++) if (vld[i] && rdy[i]) mq[i].push_back(pk[i]);
      if (g_n > 0) rr = (g_src[g_n-1] + 1) % NUM_SRC;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst   = 1'b1;
    flush = 1'b0;
    fu_wb = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
  endtask

  task automatic check_idle(input string name);
    for (int k = 0; k < CDB_PORTS; k++) begin
      check($sformatf("%s cdb%0d", name, k), 64'(cdb[k]), 64'd0);
      check($sformatf("%s src%0d", name, k), 64'(cdb_src[k]), 64'd0);
    end
    check($sformatf("%s ready", name), 64'(fu_ready), 64'hF);
  endtask

  // One model-checked cycle; acc reports which sources transferred.
  task automatic run_cycle(input logic [NUM_SRC-1:0] vld, input writeback_packet_t [NUM_SRC-1:0] pk,
                           input logic fl, input string name, output logic [NUM_SRC-1:0] acc);
    logic [NUM_SRC-1:0] erdy;
    logic [40:0] e;
    for (int i = 0; i < NUM_SRC; i++) begin
      fu_wb[i] = vld[i] ? pk[i] : '0;
      erdy[i]  = (mq[i].size() < QDEPTH);
    end
    flush = fl;
    model_predict(fl);
    @(negedge clk);
    for (int k = 0; k < CDB_PORTS; k++) begin
      e = exp_q.pop_front();
      check($sformatf("%s lane%0d", name, k), 64'({cdb_src[k], cdb[k]}), 64'(e));
    end
    check($sformatf("%s ready", name), 64'(fu_ready), 64'(erdy));
`ifdef CDB_PERF_CNT_EN
    for (int i = 0; i < NUM_SRC; i++)
      check($sformatf("%s stall%0d", name, i), 64'(stall_cnt[i]), 64'(m_stall[i]));
`endif
    @(posedge clk);
    #1;
    model_commit(vld, pk, fl, erdy);
    acc = vld & erdy;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]      vld;
    logic [3:0][4:0] tag;
    logic [3:0]      exc;
    logic            fl;
    logic [1:0]      e_vld;
    logic [1:0][4:0] e_tag;
    logic [1:0][1:0] e_src;
    logic [1:0]      e_exc;
    logic [3:0]      e_rdy;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] vld, input logic [19:0] tags, input logic [3:0] exc,
                              input logic fl, input logic [1:0] ev, input logic [9:0] etag,
                              input logic [3:0] esrc, input logic [1:0] eexc, input logic [3:0] erdy);
    vec_t v;
    v.vld = vld; v.tag = tags; v.exc = exc; v.fl = fl;
    v.e_vld = ev; v.e_tag = etag; v.e_src = esrc; v.e_exc = eexc; v.e_rdy = erdy;
    return v;
  endfunction

  vec_t vecs [23];

  // ---------------- main sequence ----------------
  initial begin
    logic [NUM_SRC-1:0] pv;
    logic [NUM_SRC-1:0] acc;
    writeback_packet_t [NUM_SRC-1:0] pp;
    writeback_packet_t ep;
    int rate;
    logic fl;

    vecs[0]  = mk(4'b0000, 20'd0, 4'd0, 1'b0, 2'b00, 10'd0, 4'd0, 2'b00, 4'hF);
    vecs[1]  = mk(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'd0, 1'b0, 2'b00, 10'd0, 4'd0, 2'b00, 4'hF);
    vecs[2]  = mk(4'b0000, 20'd0, 4'd0, 1'b0, 2'b11, {5'd2, 5'd1}, {2'd1, 2'd0}, 2'b00, 4'hF);
    vecs[3]  = mk(4'b0000, 20'd0, 4'd0, 1'b0, 2'b11, {5'd4, 5'd3}, {2'd3, 2'd2}, 2'b00, 4'hF);
    vecs[4]  = mk(4'b0000, 20'd0, 4'd0, 1'b0, 2'b00, 10'd0, 4'd0, 2'b00, 4'hF);
    vecs[5]  = mk(4'b0111, {5'd0, 5'd12, 5'd11, 5'd10}, 4'd0, 1'b0, 2'b00, 10'd0, 4'd0, 2'b00, 4'hF);
    vecs[6]  = mk(4'b0111, {5'd0, 5'd15, 5'd14, 5'd13}, 4'd0, 1'b0, 2'b11, {5'd11, 5'd10}, {2'd1, 2'd0}, 2'b00, 4'hF);
    vecs[7]  = mk(4'b0100, {5'd0, 5'd16, 5'd0, 5'd0}, 4'd0, 1'b0, 2'b11, {5'd13, 5'd12}, {2'd0, 2'd2}, 2'b00, 4'b1011);
    vecs[8]  = mk(4'b0100, {5'd0, 5'd16, 5'd0, 5'd0}, 4'd0, 1'b0, 2'b11, {5'd15, 5'd14}, {2'd2, 2'd1}, 2'b00, 4'hF);
    vecs[9]  = mk(4'b0000, 20'd0, 4'd0, 1'b0, 2'b01, {5'd0, 5'd16}, {2'd0, 2'd2}, 2'b00, 4'hF);
    vecs[10] = mk(4'b0000, 20'd0, 4'd0, 1'b0, 2'b00, 10'd0, 4'd0, 2'b00, 4'hF);
    vecs[11] = mk(4'b1111, {5'd23, 5'd22, 5'd21, 5'd20}, 4'd0, 1'b0, 2'b00, 10'd0, 4'd0, 2'b00, 4'hF);
    vecs[12] = mk(4'b0001, {5'd0, 5'd0, 5'd0, 5'd24}, 4'd0, 1'b1, 2'b00, 10'd0, 4'd0, 2'b00, 4'hF);
    vecs[13] = mk(4'b0000, 20'd0, 4'd0, 1'b0, 2'b00, 10'd0, 4'd0, 2'b00, 4'hF);
    vecs[14] = mk(4'b1000, {5'd31, 5'd0, 5'd0, 5'd0}, 4'b1000, 1'b0, 2'b00, 10'd0, 4'd0, 2'b00, 4'hF);
    vecs[15] = mk(4'b0000, 20'd0, 4'd0, 1'b0, 2'b01, {5'd0, 5'd31}, {2'd0, 2'd3}, 2'b01, 4'hF);
    vecs[16] = mk(4'b0000, 20'd0, 4'd0, 1'b0, 2'b00, 10'd0, 4'd0, 2'b00, 4'hF);
    vecs[17] = mk(4'b1111, {5'd8, 5'd7, 5'd6, 5'd5}, 4'd0, 1'b0, 2'b00, 10'd0, 4'd0, 2'b00, 4'hF);
    vecs[18] = mk(4'b0000, 20'd0, 4'd0, 1'b0, 2'b11, {5'd6, 5'd5}, {2'd1, 2'd0}, 2'b00, 4'hF);
    vecs[19] = mk(4'b0000, 20'd0, 4'd0, 1'b1, 2'b00, 10'd0, 4'd0, 2'b00, 4'hF);
    vecs[20] = mk(4'b1001, {5'd27, 5'd0, 5'd0, 5'd25}, 4'd0, 1'b0, 2'b00, 10'd0, 4'd0, 2'b00, 4'hF);
    vecs[21] = mk(4'b0000, 20'd0, 4'd0, 1'b0, 2'b11, {5'd25, 5'd27}, {2'd0, 2'd3}, 2'b00, 4'hF);
    vecs[22] = mk(4'b0000, 20'd0, 4'd0, 1'b0, 2'b00, 10'd0, 4'd0, 2'b00, 4'hF);

    // Reset state, then a single ALU0 packet with one cycle of latency.
    do_reset();
    @(negedge clk);
    check_idle("reset");
    fu_wb[0] = pkt(5'd3, 32'h1234, 1'b0);
    #1;
    check("t1 no bypass", 64'(cdb[0]), 64'd0);
    @(posedge clk);
    #1 fu_wb = '0;
    @(negedge clk);
    check("t1 lane0", 64'(cdb[0]), 64'({5'd3, 32'h1234, 1'b1, 1'b0}));
    check("t1 src0", 64'(cdb_src[0]), 64'd0);
    check("t1 lane1", 64'(cdb[1]), 64'd0);
    @(negedge clk);
    check_idle("t1 idle");

    // Reset while packets are queued discards them.
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_SRC; i++) fu_wb[i] = pkt(5'(i + 1), res_of(5'(i + 1)), 1'b0);
    @(posedge clk);
    #1 fu_wb = '0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("rst_mid");
    @(negedge clk);
    check_idle("rst_mid+1");

    // Directed table.
    do_reset();
    for (int r = 0; r < 23; r++) begin
      for (int i = 0; i < NUM_SRC; i++)
        fu_wb[i] = vecs[r].vld[i] ? pkt(vecs[r].tag[i], res_of(vecs[r].tag[i]), vecs[r].exc[i]) : '0;
      flush = vecs[r].fl;
      @(negedge clk);
      for (int k = 0; k < CDB_PORTS; k++) begin
        ep = vecs[r].e_vld[k] ? pkt(vecs[r].e_tag[k], res_of(vecs[r].e_tag[k]), vecs[r].e_exc[k]) : '0;
        check($sformatf("vec%0d lane%0d", r, k), 64'(cdb[k]), 64'(ep));
        check($sformatf("vec%0d src%0d", r, k), 64'(cdb_src[k]),
              vecs[r].e_vld[k] ? 64'(vecs[r].e_src[k]) : 64'd0);
      end
      check($sformatf("vec%0d ready", r), 64'(fu_ready), 64'(vecs[r].e_rdy));
      @(posedge clk);
      #1;
    end
    flush = 1'b0;
    fu_wb = '0;

    // Randomized traffic with FUs holding unaccepted packets.
    do_reset();
    pv   = '0;
    pp   = '0;
    rate = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 300 == 0) rate = $urandom_range(20, 100);
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!pv[i] && $urandom_range(1, 100) <= rate) begin
          pv[i] = 1'b1;
          pp[i] = pkt(5'($urandom), $urandom, ($urandom_range(0, 7) == 0));
        end
      end
      fl = ($urandom_range(0, 49) == 0);
      run_cycle(pv, pp, fl, $sformatf("rnd%0d", c), acc);
      pv = pv & ~acc;
    end

`ifdef CDB_PERF_CNT_EN
    // All sources saturated for ten cycles, then reset clears the counters.
    do_reset();
    pv = '0;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!pv[i]) begin
          pv[i] = 1'b1;
          pp[i] = pkt(5'($urandom), $urandom, 1'b0);
        end
      end
      run_cycle(pv, pp, 1'b0, $sformatf("perf%0d", c), acc);
      pv = pv & ~acc;
    end
    do_reset();
    @(negedge clk);
    for (int i = 0; i < NUM_SRC; i++)
      check($sformatf("perf rst stall%0d", i), 64'(stall_cnt[i]), 64'd0);
`endif

    flush = 1'b0;
    fu_wb = '0;
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
